// File: rtl/apb_mem_bridge.sv
// APB4 slave front-end: decodes region/alignment/protection and bridges to
// one-hot memory targets. Optional watchdog timeout under `APB_TIMEOUT_EN.
module apb_mem_bridge #(
    parameter int                     DATA_W      = 64,
    parameter int                     ADDR_W      = 32,
    parameter int                     NUM_REGIONS = 4,
    parameter int                     REGION_AW   = 12,
    parameter logic [NUM_REGIONS-1:0] PRIV_MASK   = '0,
    parameter int                     TIMEOUT_CYC = 256
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [ADDR_W-1:0]      PADDR,
    input  logic [DATA_W-1:0]      PWDATA,
    input  logic [DATA_W/8-1:0]    PSTRB,
    input  logic [2:0]             PPROT,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [DATA_W-1:0]      PRDATA,
    output logic [NUM_REGIONS-1:0] mem_req,
    output logic                   mem_we,
    output logic [REGION_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [DATA_W/8-1:0]    mem_be,
    input  logic                   mem_ack,
    input  logic                   mem_err,
    input  logic [DATA_W-1:0]      mem_rdata
);
    localparam int SW     = DATA_W / 8;
    localparam int OW     = $clog2(SW);
    localparam int IW_RAW = $clog2(NUM_REGIONS);
    localparam int IW     = (IW_RAW == 0) ? 1 : IW_RAW;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_in;
    logic          dec_err;
    logic          setup;
    logic          err_flag;
    logic          expire;
    logic          unused;

    assign setup  = (state == IDLE) && PSEL && !PENABLE;
    assign idx_in = PADDR[REGION_AW +: IW];
    assign unused = ^{PPROT[2:1], 32'(TIMEOUT_CYC)};

    always_comb begin
        dec_err = 1'b0;
        if ((PADDR >> (REGION_AW + IW_RAW)) != '0) dec_err = 1'b1;
        if (PADDR[OW-1:0] != '0) dec_err = 1'b1;
        if (!PPROT[0] && PRIV_MASK[idx_in]) dec_err = 1'b1;
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    // Fires on the ACCESS cycle whose increment would reach the limit.
    assign expire = (state == ACCESS) && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET || setup)
            cnt <= '0;
        else if (state == ACCESS && !mem_ack)
            cnt <= cnt + CW'(1);
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (setup) state_nxt = dec_err ? ERR : ACCESS;
            ACCESS:
                if (!PSEL)
                    state_nxt = IDLE;
                else if (mem_ack || expire)
                    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            idx       <= '0;
            err_flag  <= 1'b0;
            PRDATA    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state <= state_nxt;
            if (setup) begin
                idx       <= idx_in;
                mem_we    <= PWRITE;
                mem_addr  <= PADDR[REGION_AW-1:0];
                mem_wdata <= PWDATA;
                mem_be    <= PWRITE ? PSTRB : '1;
                PRDATA    <= '0;
                err_flag  <= 1'b0;
            end else if (state == ACCESS && PSEL) begin
                if (mem_ack) begin
                    err_flag <= mem_err;
                    if (!mem_we) PRDATA <= mem_rdata;
                end else if (expire) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

    assign mem_req = (state == ACCESS) ? (NUM_REGIONS'(1) << idx) : '0;
    assign PREADY  = (state == RESP) || (state == ERR);
    assign PSLVERR = (state == ERR) || ((state == RESP) && err_flag);

endmodule
